// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg
// Shared definitions for the M-stage exception resolver:
//   - CODE_W           : width of the internal exception code
//   - EXC_* constants  : named exception codes
//   - EXC_DEFAULT_CODES: flat per-source code table, source i at [i*CODE_W +: CODE_W]
//   - is_badv_code()   : true for codes that also load BadVAddr
//   - state_t          : resolver FSM states
// ---------------------------------------------------------------------------
package exc_pkg;

    localparam int CODE_W = 5;
    localparam int N_SRC_DEFAULT = 12;

    localparam logic [CODE_W-1:0] EXC_INT          = 5'h01;
    localparam logic [CODE_W-1:0] EXC_ADEL         = 5'h04;
    localparam logic [CODE_W-1:0] EXC_ADES         = 5'h05;
    localparam logic [CODE_W-1:0] EXC_SYS          = 5'h08;
    localparam logic [CODE_W-1:0] EXC_BP           = 5'h09;
    localparam logic [CODE_W-1:0] EXC_RI           = 5'h0a;
    localparam logic [CODE_W-1:0] EXC_OV           = 5'h0c;
    localparam logic [CODE_W-1:0] EXC_ERET         = 5'h0e;
    localparam logic [CODE_W-1:0] EXC_ITLB_REFILL  = 5'h10;
    localparam logic [CODE_W-1:0] EXC_ITLB_INVALID = 5'h11;
    localparam logic [CODE_W-1:0] EXC_DTLB_REFILL  = 5'h12;
    localparam logic [CODE_W-1:0] EXC_DTLB_INVALID = 5'h13;
    localparam logic [CODE_W-1:0] EXC_TLBMOD       = 5'h14;

    // Highest index on the left so that source 0 lands in the low bits.
    localparam logic [N_SRC_DEFAULT*CODE_W-1:0] EXC_DEFAULT_CODES = {
        EXC_TLBMOD,        // 11
        EXC_DTLB_INVALID,  // 10
        EXC_DTLB_REFILL,   // 9
        EXC_OV,            // 8
        EXC_RI,            // 7
        EXC_ERET,          // 6
        EXC_BP,            // 5
        EXC_SYS,           // 4
        EXC_ITLB_INVALID,  // 3
        EXC_ITLB_REFILL,   // 2
        EXC_ADES,          // 1
        EXC_ADEL           // 0
    };

    // Codes whose handler needs the faulting address in BadVAddr.
    function automatic logic is_badv_code(input logic [7:0] code);
        return code inside {8'(EXC_ADEL), 8'(EXC_ADES),
                            [8'(EXC_ITLB_REFILL) : 8'(EXC_TLBMOD)]};
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/irq_sync.sv
// ---------------------------------------------------------------------------
// irq_sync
// Per-bit multi-flop synchroniser for asynchronous interrupt lines.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   irq_in      : raw asynchronous lines
//   irq_sync    : lines after STAGES flops (STAGES must be >= 2)
// ---------------------------------------------------------------------------
module irq_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] irq_in,
    output logic [WIDTH-1:0] irq_sync
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: the chain is a handful of flops, not a RAM, so every stage is
    // reset; a stale interrupt must not survive reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= irq_in;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign irq_sync = stage_q[STAGES-1];

endmodule

// File: rtl/exc_resolver.sv
// ---------------------------------------------------------------------------
// exc_resolver
// Memory-stage exception resolver. Picks the highest-priority cause for the
// presented instruction (interrupt first, then in_req in ascending index),
// latches code/EPC/BD/BadVAddr and holds exc_valid until exc_ack.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   irq_in               : async interrupt lines -> irq_sync (Cause.IP[N_IRQ+1:2])
//   status, cause_ip_sw  : CP0 Status (IM, EXL, IE) and Cause.IP[1:0]
//   in_valid / in_ready  : instruction handshake
//   in_req, in_pc, in_bd, in_badvaddr : per-instruction exception data
//   exc_valid / exc_ack  : held flush request and its acknowledge
//   exc_code, exc_epc, exc_bd, exc_badvaddr, exc_badvaddr_we : latched result
// ---------------------------------------------------------------------------
module exc_resolver
    import exc_pkg::*;
#(
    parameter int                        N_IRQ       = 6,
    parameter int                        N_SRC       = 12,
    parameter int                        CODE_W      = exc_pkg::CODE_W,
    parameter logic [N_SRC*CODE_W-1:0]   SRC_CODES   = exc_pkg::EXC_DEFAULT_CODES,
    parameter int                        SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic [31:0]       status,
    input  logic [1:0]        cause_ip_sw,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_SRC-1:0]  in_req,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [31:0]       in_badvaddr,
    output logic [N_IRQ-1:0]  irq_sync,
    output logic              exc_valid,
    input  logic              exc_ack,
    output logic [CODE_W-1:0] exc_code,
    output logic [31:0]       exc_epc,
    output logic              exc_bd,
    output logic [31:0]       exc_badvaddr,
    output logic              exc_badvaddr_we
);

    state_t              state;
    logic [7:0]          ip;
    logic                int_take;
    logic                src_hit;
    logic [CODE_W-1:0]   src_code;
    logic                hit;
    logic [CODE_W-1:0]   sel_code;
    logic [31:0]         epc_next;
    logic                accept;

    irq_sync #(
        .WIDTH  (N_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk      (clk),
        .resetn   (resetn),
        .irq_in   (irq_in),
        .irq_sync (irq_sync)
    );

    // Pending-interrupt vector as seen by Cause.IP; unused upper bits are 0.
    // NOTE: every variable in a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ip = '0;
        ip[N_IRQ+1:0] = {irq_sync, cause_ip_sw};
    end

    assign int_take = (|(ip & status[15:8])) && !status[1] && status[0];

    // Scan from the lowest-priority source upward so source 0 wins last.
    always_comb begin
        src_hit  = 1'b0;
        src_code = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (in_req[i]) begin
                src_hit  = 1'b1;
                src_code = SRC_CODES[i*CODE_W +: CODE_W];
            end
        end
    end

    assign hit      = int_take || src_hit;
    assign sel_code = int_take ? CODE_W'(EXC_INT) : src_code;
    // 32-bit subtraction wraps naturally for a branch at address 0.
    assign epc_next = in_bd ? (in_pc - 32'd4) : in_pc;
    assign accept   = in_valid && in_ready;

    // Single registered FSM: in_ready and exc_valid are flops, so the
    // outputs carry no combinational path from the in_* ports.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            in_ready        <= 1'b0;
            exc_valid       <= 1'b0;
            exc_code        <= '0;
            exc_epc         <= '0;
            exc_bd          <= 1'b0;
            exc_badvaddr    <= '0;
            exc_badvaddr_we <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept && hit) begin
                        state           <= ST_HOLD;
                        in_ready        <= 1'b0;
                        exc_valid       <= 1'b1;
                        exc_code        <= sel_code;
                        exc_epc         <= epc_next;
                        exc_bd          <= in_bd;
                        exc_badvaddr    <= in_badvaddr;
                        exc_badvaddr_we <= is_badv_code(8'(sel_code));
                    end
                end
                ST_HOLD: begin
                    // Held data stays put; only the acknowledge releases it.
                    if (exc_ack) begin
                        state           <= ST_IDLE;
                        in_ready        <= 1'b1;
                        exc_valid       <= 1'b0;
                        exc_badvaddr_we <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    exc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_resolver.sv
// ---------------------------------------------------------------------------
// tb_exc_resolver
// Directed vectors with hand-computed expectations for exc_resolver.
// ---------------------------------------------------------------------------
module tb_exc_resolver;

    logic        clk;
    logic        resetn;
    logic [5:0]  irq_in;
    logic [31:0] status;
    logic [1:0]  cause_ip_sw;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_req;
    logic [31:0] in_pc;
    logic        in_bd;
    logic [31:0] in_badvaddr;
    logic [5:0]  irq_sync;
    logic        exc_valid;
    logic        exc_ack;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        exc_badvaddr_we;

    int n_tests = 0;
    int n_fail  = 0;

    exc_resolver dut (
        .clk             (clk),
        .resetn          (resetn),
        .irq_in          (irq_in),
        .status          (status),
        .cause_ip_sw     (cause_ip_sw),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_req          (in_req),
        .in_pc           (in_pc),
        .in_bd           (in_bd),
        .in_badvaddr     (in_badvaddr),
        .irq_sync        (irq_sync),
        .exc_valid       (exc_valid),
        .exc_ack         (exc_ack),
        .exc_code        (exc_code),
        .exc_epc         (exc_epc),
        .exc_bd          (exc_bd),
        .exc_badvaddr    (exc_badvaddr),
        .exc_badvaddr_we (exc_badvaddr_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle, then drop in_valid.
    task automatic present(input logic [11:0] req, input logic [31:0] pc,
                           input logic bd, input logic [31:0] badv);
        in_valid    = 1'b1;
        in_req      = req;
        in_pc       = pc;
        in_bd       = bd;
        in_badvaddr = badv;
        tick();
        in_valid    = 1'b0;
        in_req      = '0;
    endtask

    // Acknowledge for one cycle and confirm the return to IDLE.
    task automatic ack(input string tag);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        check({tag, "_ack_valid"}, 32'(exc_valid), 32'd0);
        check({tag, "_ack_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cycles;
        bit seen;

        resetn      = 1'b0;
        irq_in      = '0;
        status      = '0;
        cause_ip_sw = '0;
        in_valid    = 1'b0;
        in_req      = '0;
        in_pc       = '0;
        in_bd       = 1'b0;
        in_badvaddr = '0;
        exc_ack     = 1'b0;

        // Reset state
        #12;
        check("rst_valid",    32'(exc_valid), 32'd0);
        check("rst_ready",    32'(in_ready),  32'd0);
        check("rst_code",     32'(exc_code),  32'd0);
        check("rst_epc",      exc_epc,        32'd0);
        check("rst_irq_sync", 32'(irq_sync),  32'd0);
        #5 resetn = 1'b1;
        tick();
        check("post_rst_ready", 32'(in_ready),  32'd1);
        check("post_rst_valid", 32'(exc_valid), 32'd0);

        // Interrupt beats a synchronous source
        status      = 32'h0000_FF01;
        cause_ip_sw = 2'b01;
        present(12'h002, 32'h0000_1000, 1'b0, 32'hDEAD_BEEF);
        check("prio_valid", 32'(exc_valid),       32'd1);
        check("prio_code",  32'(exc_code),        32'h01);
        check("prio_bvwe",  32'(exc_badvaddr_we), 32'd0);
        check("prio_ready", 32'(in_ready),        32'd0);
        ack("prio");

        // EXL=1 blocks the interrupt, AdES wins
        status = 32'h0000_FF03;
        present(12'h002, 32'h0000_1000, 1'b0, 32'hDEAD_BEEF);
        check("exl_code", 32'(exc_code),        32'h05);
        check("exl_bvwe", 32'(exc_badvaddr_we), 32'd1);
        check("exl_bva",  exc_badvaddr,         32'hDEAD_BEEF);
        ack("exl");

        status      = '0;
        cause_ip_sw = '0;

        // Source order: lowest set index wins
        present(12'h1A0, 32'h0000_2000, 1'b0, 32'h0);
        check("order_code", 32'(exc_code),        32'h09);
        check("order_bvwe", 32'(exc_badvaddr_we), 32'd0);
        ack("order");

        present(12'h800, 32'h0000_3000, 1'b0, 32'h1234_5678);
        check("tlbmod_code", 32'(exc_code),        32'h14);
        check("tlbmod_bvwe", 32'(exc_badvaddr_we), 32'd1);
        check("tlbmod_bva",  exc_badvaddr,         32'h1234_5678);
        ack("tlbmod");

        // Delay slot EPC
        present(12'h010, 32'hBFC0_0004, 1'b1, 32'h0);
        check("bd_epc",  exc_epc,          32'hBFC0_0000);
        check("bd_bd",   32'(exc_bd),      32'd1);
        check("bd_code", 32'(exc_code),    32'h08);
        ack("bd");

        // EPC wrap, then hold while upstream keeps pushing
        present(12'h001, 32'h0000_0000, 1'b1, 32'hAAAA_0000);
        check("wrap_epc",  exc_epc,     32'hFFFF_FFFC);
        check("wrap_bd",   32'(exc_bd), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid    = 1'b1;
            in_req      = 12'h800;
            in_pc       = 32'h5000_0000 + 32'(i);
            in_bd       = 1'b0;
            in_badvaddr = 32'h5555_0000;
            tick();
            check("hold_valid", 32'(exc_valid), 32'd1);
            check("hold_ready", 32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        in_req   = '0;
        check("hold_code", 32'(exc_code),  32'h04);
        check("hold_epc",  exc_epc,        32'hFFFF_FFFC);
        check("hold_bva",  exc_badvaddr,   32'hAAAA_0000);
        check("hold_bd",   32'(exc_bd),    32'd1);
        ack("hold");

        // No hit stays idle
        present(12'h000, 32'h0000_4000, 1'b0, 32'h0);
        check("nohit_valid", 32'(exc_valid), 32'd0);
        check("nohit_ready", 32'(in_ready),  32'd1);

        // Pending interrupt on a bubble is not taken
        status      = 32'h0000_FF01;
        cause_ip_sw = 2'b01;
        tick();
        tick();
        check("bubble_valid", 32'(exc_valid), 32'd0);
        cause_ip_sw = 2'b00;

        // Synchroniser latency: rise lands between edges
        in_valid = 1'b1;
        in_req   = '0;
        in_pc    = 32'h0000_6000;
        in_bd    = 1'b0;
        irq_in   = 6'b000001;
        cycles   = 0;
        seen     = 1'b0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            tick();
            if (exc_valid) begin
                cycles = i;
                seen   = 1'b1;
            end
        end
        in_valid = 1'b0;
        irq_in   = '0;
        check("sync_latency",  32'(cycles),    32'd3);
        check("sync_code",     32'(exc_code),  32'h01);
        check("sync_epc",      exc_epc,        32'h0000_6000);
        ack("sync");
        tick();
        tick();
        tick();
        status = '0;

        // Reset mid-HOLD
        irq_in = 6'b000010;
        present(12'h001, 32'h0000_7000, 1'b0, 32'h0);
        tick();
        check("mrst_pre_valid", 32'(exc_valid), 32'd1);
        check("mrst_pre_sync",  32'(irq_sync),  32'h02);
        #2 resetn = 1'b0;
        #1;
        check("mrst_valid", 32'(exc_valid), 32'd0);
        check("mrst_sync",  32'(irq_sync),  32'd0);
        check("mrst_code",  32'(exc_code),  32'd0);
        check("mrst_ready", 32'(in_ready),  32'd0);
        irq_in = '0;
        resetn = 1'b1;
        tick();
        check("mrst_rel_ready", 32'(in_ready),  32'd1);
        check("mrst_rel_valid", 32'(exc_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
